mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one mem_system port between two requesters: the instruction-fetch side (I) and the data-memory side (D).
- Sits between the fetch stage and the data memory stage on one side and a single cache/memory instance on the other.
- Grants one transaction at a time, holds it until completion, routes the response back to the owner, and enforces a watchdog timeout.

Parameters:
- TIMEOUT, 64, max cycles a granted transaction may run without mem_done; on expiry the owner gets err and the arbiter returns to IDLE.
- CNT_W, 7, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_rd  in  1  fetch read request; held high until i_done
- i_addr  in  16  fetch address
- i_data_out  out  16  fetch read data; valid when i_done
- i_done  out  1  fetch transaction complete (1-cycle pulse)
- i_stall  out  1  fetch must hold request
- i_err  out  1  fetch error; valid with i_done
- d_rd  in  1  data read request; held until d_done
- d_wr  in  1  data write request; held until d_done
- d_addr  in  16  data address
- d_data_in  in  16  write data
- d_data_out  out  16  read data; valid when d_done
- d_done  out  1  data transaction complete (1-cycle pulse)
- d_stall  out  1  data side must hold request
- d_err  out  1  data error; valid with d_done
- mem_addr  out  16  to mem_system Addr
- mem_data_in  out  16  to mem_system DataIn
- mem_rd  out  1  to mem_system Rd
- mem_wr  out  1  to mem_system Wr
- mem_data_out  in  16  from mem_system DataOut
- mem_done  in  1  from mem_system Done
- mem_stall  in  1  from mem_system Stall; informational only
- mem_err  in  1  from mem_system err

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: state=IDLE, prio=D, watchdog=0.
- Reset outputs: mem_rd, mem_wr, mem_addr, mem_data_in all 0 (registered). All done/err outputs 0.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration:
  - Only i_rd high -> BUSY_I.
  - Only (d_rd|d_wr) high -> BUSY_D.
  - Both high -> grant side = prio.
- On the grant edge, register into mem_* for the whole transaction:
  - address from the granted requester;
  - d_data_in when granted to D;
  - mem_rd / mem_wr per the granted op; d_wr wins if d_rd and d_wr are both high.
- mem_rd/mem_wr stay asserted every cycle in BUSY_* until mem_done; they deassert on the edge after mem_done.
- Completion in BUSY_x on a mem_done cycle:
  - x_done=1 the same cycle (combinational passthrough);
  - x_data_out=mem_data_out; x_err=mem_err;
  - next state IDLE;
  - prio toggles to the other side.
- If the owner dropped its request before mem_done, the transaction still completes, but x_done is suppressed.
- Stall: x_stall = x request high and not (owner==x and mem_done). The non-owner is stalled for the entire transaction.
- Timing:
  - Request seen in IDLE at cycle t -> mem_rd/mem_wr high at t+1.
  - Back-to-back: mem_done at t -> IDLE at t+1 -> next mem_rd at t+2.
  - Minimum one-cycle bubble between transactions.
- Watchdog:
  - Clears on grant and increments each BUSY cycle.
  - When it reaches TIMEOUT without mem_done: x_done=1, x_err=1, data=0; mem_rd/mem_wr drop next edge; state IDLE; prio toggles.
- mem_done seen in IDLE is ignored: no done is forwarded.
- rst mid-transaction: IDLE and all mem_* = 0 on that edge; the in-flight response is discarded.
- Data outputs are 0 when the corresponding done is low.

Decomposition:
- Shared package holds:
  - state encodings (IDLE=2'b00, BUSY_I=2'b01, BUSY_D=2'b10);
  - owner encoding (OWN_I=0, OWN_D=1);
  - default TIMEOUT.
- One natural sub-module: arb_watchdog (load/clear, count, expired flag).
- Register the FSM, prio and mem_* using the standard register cell.

Test Plan:
- Fetch only: i_rd=1, i_addr=16'h0010; mem_done at 3rd BUSY cycle with data 16'h1234 -> i_done pulse with i_data_out=16'h1234, i_err=0. mem_rd high exactly 3 cycles.
- Simultaneous requests after reset: i_rd=1, d_rd=1, d_addr=16'h0200 -> D granted first (mem_addr=16'h0200). After its done, I is granted with a 1-cycle bubble. Repeat both -> D is still served first, since prio toggled to I after the D grant and back to D after the I grant.
- Write priority and data: d_rd=d_wr=1, d_addr=16'h0040, d_data_in=16'hBEEF -> mem_wr=1, mem_rd=0, mem_data_in=16'hBEEF held until mem_done.
- Timeout: grant I, never assert mem_done -> after 64 BUSY cycles i_done=1, i_err=1, i_data_out=0. State returns to IDLE and mem_rd is 0 the next cycle.
- Error passthrough and drop: mem_err=1 with mem_done -> d_err=1 with d_done. Separately, drop i_rd mid-transaction -> no i_done pulse, and the arbiter returns to IDLE.
- Reset mid-transaction: rst high during BUSY_D -> next cycle mem_wr=mem_rd=0, IDLE, prio=D. A later mem_done does not produce d_done.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I/D memory-port arbiter: FSM and owner
// encodings, default watchdog sizing and a small owner helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY_I = 2'b01,
    ST_BUSY_D = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int unsigned DEF_TIMEOUT = 64;
  localparam int unsigned DEF_CNT_W   = 7;

  // The side that gets priority after 'o' has been served.
  function automatic owner_e other_side(input owner_e o);
    owner_e r;
    if (o == OWN_I) begin
      r = OWN_D;
    end else begin
      r = OWN_I;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_watchdog.sv
// Transaction watchdog: cleared on grant/completion, counts every busy
// cycle and flags expiry once TIMEOUT busy cycles have elapsed.
module arb_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one mem_system port between the fetch (I) and data (D) sides.
// One transaction at a time, alternating priority on contention, response
// routed back to the owner, watchdog abort on a missing mem_done.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd,
  input  logic [15:0] i_addr,
  output logic [15:0] i_data_out,
  output logic        i_done,
  output logic        i_stall,
  output logic        i_err,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data_in,
  output logic [15:0] d_data_out,
  output logic        d_done,
  output logic        d_stall,
  output logic        d_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_done,
  input  logic        mem_stall,
  input  logic        mem_err
);

  arb_state_e  state_q, state_d;
  owner_e      prio_q, prio_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_data_in_q, mem_data_in_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;

  logic        d_req_s;
  logic        busy_s;
  owner_e      owner_s;
  logic        grant_s;
  logic        wd_expired_s;
  logic        fin_s;
  logic        unused_mem_stall_s;

  // mem_stall is informational; completion is signalled by mem_done alone.
  assign unused_mem_stall_s = mem_stall;

  assign d_req_s = d_rd | d_wr;
  assign busy_s  = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
  assign owner_s = (state_q == ST_BUSY_D) ? OWN_D : OWN_I;
  // A transaction ends on mem_done or watchdog expiry, whichever is first.
  assign fin_s   = busy_s & (mem_done | wd_expired_s);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wd (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (grant_s | fin_s),
    .en_i      (busy_s),
    .expired_o (wd_expired_s)
  );

  // Arbitration, next state, priority and the latched mem_* request.
  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    mem_rd_d      = mem_rd_q;
    mem_wr_d      = mem_wr_q;
    grant_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rd && (!d_req_s || (prio_q == OWN_I))) begin
          state_d       = ST_BUSY_I;
          grant_s       = 1'b1;
          mem_addr_d    = i_addr;
          mem_data_in_d = 16'h0000;
          mem_rd_d      = 1'b1;
          mem_wr_d      = 1'b0;
        end else if (d_req_s) begin
          state_d       = ST_BUSY_D;
          grant_s       = 1'b1;
          mem_addr_d    = d_addr;
          mem_data_in_d = d_data_in;
          // A write wins when both ops are requested together.
          mem_wr_d      = d_wr;
          mem_rd_d      = d_rd & ~d_wr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (fin_s) begin
          state_d       = ST_IDLE;
          prio_d        = other_side(owner_s);
          mem_addr_d    = 16'h0000;
          mem_data_in_d = 16'h0000;
          mem_rd_d      = 1'b0;
          mem_wr_d      = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  // FSM, priority and mem_* request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      prio_q        <= OWN_D;
      mem_addr_q    <= 16'h0000;
      mem_data_in_q <= 16'h0000;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;

  // Response routing to the owner plus stall generation for both sides.
  always_comb begin
    i_done     = 1'b0;
    i_err      = 1'b0;
    i_data_out = 16'h0000;
    d_done     = 1'b0;
    d_err      = 1'b0;
    d_data_out = 16'h0000;
    if ((state_q == ST_BUSY_I) && fin_s && i_rd) begin
      i_done     = 1'b1;
      i_data_out = mem_done ? mem_data_out : 16'h0000;
      i_err      = mem_done ? mem_err : 1'b1;
    end else begin
      i_done = 1'b0;
    end
    if ((state_q == ST_BUSY_D) && fin_s && d_req_s) begin
      d_done     = 1'b1;
      d_data_out = mem_done ? mem_data_out : 16'h0000;
      d_err      = mem_done ? mem_err : 1'b1;
    end else begin
      d_done = 1'b0;
    end
    i_stall = i_rd & ~((state_q == ST_BUSY_I) & mem_done);
    d_stall = d_req_s & ~((state_q == ST_BUSY_D) & mem_done);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// random rounds, all checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd;
  logic [15:0] i_addr;
  logic [15:0] i_data_out;
  logic        i_done, i_stall, i_err;
  logic        d_rd, d_wr;
  logic [15:0] d_addr, d_data_in, d_data_out;
  logic        d_done, d_stall, d_err;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_rd, mem_wr, mem_done, mem_stall, mem_err;

  int checks   = 0;
  int failures = 0;
  // Model: which side wins a tie in IDLE (1 = D, 0 = I).
  bit m_prio_d = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_rd         (i_rd),
    .i_addr       (i_addr),
    .i_data_out   (i_data_out),
    .i_done       (i_done),
    .i_stall      (i_stall),
    .i_err        (i_err),
    .d_rd         (d_rd),
    .d_wr         (d_wr),
    .d_addr       (d_addr),
    .d_data_in    (d_data_in),
    .d_data_out   (d_data_out),
    .d_done       (d_done),
    .d_stall      (d_stall),
    .d_err        (d_err),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_data_out (mem_data_out),
    .mem_done     (mem_done),
    .mem_stall    (mem_stall),
    .mem_err      (mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction starting from the current IDLE cycle with requests
  // already driven. lat = BUSY cycle carrying mem_done; tmo = never answer;
  // drop_at = BUSY cycle on which the owner withdraws (0 = never);
  // idle_md = pulse a stray mem_done in the IDLE cycle.
  task automatic txn(input string tag, input int lat, input bit tmo, input int drop_at,
                     input logic err_b, input logic [15:0] rdata, input bit idle_md);
    bit          own_d, ireq, dreq, req_own, md, de;
    logic [15:0] ea;
    logic        erd, ewr;
    logic [1:0]  edone;
    int          fin_cyc;
    ireq = i_rd;
    dreq = d_rd | d_wr;
    own_d = (ireq && dreq) ? m_prio_d : dreq;
    ea  = own_d ? d_addr : i_addr;
    ewr = own_d & d_wr;
    erd = ~ewr;
    if (idle_md) begin
      mem_done = 1'b1; mem_err = 1'b1; mem_data_out = 16'hDEAD;
    end
    #1;
    chk({tag, ":idle_mem_rd"}, mem_rd, 32'd0);
    chk({tag, ":idle_mem_wr"}, mem_wr, 32'd0);
    chk({tag, ":idle_done"}, {i_done, d_done}, 32'd0);
    chk({tag, ":idle_stall"}, {i_stall, d_stall}, {30'd0, ireq, dreq});
    mem_done = 1'b0; mem_err = 1'b0;
    fin_cyc = tmo ? TO + 1 : lat;
    for (int c = 1; c <= fin_cyc; c++) begin
      tick();
      if (drop_at == c) begin
        if (own_d) begin d_rd = 1'b0; d_wr = 1'b0; end
        else i_rd = 1'b0;
      end
      md = !tmo && (c == fin_cyc);
      if (md) begin
        mem_done = 1'b1; mem_data_out = rdata; mem_err = err_b;
      end
      #1;
      req_own = own_d ? (d_rd | d_wr) : i_rd;
      chk({tag, ":mem_addr"}, mem_addr, {16'd0, ea});
      chk({tag, ":mem_rd"}, mem_rd, {31'd0, erd});
      chk({tag, ":mem_wr"}, mem_wr, {31'd0, ewr});
      if (own_d) chk({tag, ":mem_data_in"}, mem_data_in, {16'd0, d_data_in});
      de = (c == fin_cyc) && req_own;
      edone = own_d ? {1'b0, de} : {de, 1'b0};
      chk({tag, ":done"}, {i_done, d_done}, {30'd0, edone});
      if (de) begin
        chk({tag, ":data"}, own_d ? d_data_out : i_data_out, tmo ? 32'd0 : {16'd0, rdata});
        chk({tag, ":err"}, own_d ? d_err : i_err, tmo ? 32'd1 : {31'd0, err_b});
        chk({tag, ":other_data"}, own_d ? i_data_out : d_data_out, 32'd0);
      end else begin
        chk({tag, ":data_idle"}, {i_data_out, d_data_out}, 32'd0);
      end
      chk({tag, ":i_stall"}, i_stall, {31'd0, i_rd & ~(~own_d & md)});
      chk({tag, ":d_stall"}, d_stall, {31'd0, (d_rd | d_wr) & ~(own_d & md)});
    end
    tick();
    mem_done = 1'b0; mem_err = 1'b0; mem_data_out = 16'($urandom);
    if (own_d) begin d_rd = 1'b0; d_wr = 1'b0; end
    else i_rd = 1'b0;
    m_prio_d = ~own_d;
    #1;
    chk({tag, ":bubble_rd"}, mem_rd, 32'd0);
    chk({tag, ":bubble_wr"}, mem_wr, 32'd0);
    chk({tag, ":bubble_done"}, {i_done, d_done}, 32'd0);
  endtask

  initial begin
    int op;
    rst = 1'b1; i_rd = 1'b0; i_addr = 16'h0000;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = 16'h0000; d_data_in = 16'h0000;
    mem_data_out = 16'h0000; mem_done = 1'b0; mem_stall = 1'b0; mem_err = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst:mem_rd", mem_rd, 32'd0);
    chk("rst:mem_wr", mem_wr, 32'd0);
    chk("rst:mem_addr", mem_addr, 32'd0);
    chk("rst:mem_data_in", mem_data_in, 32'd0);
    chk("rst:done_err", {i_done, d_done, i_err, d_err}, 32'd0);

    // Simultaneous requests: D first, then I after a bubble, twice.
    i_rd = 1'b1; i_addr = 16'h0100; d_rd = 1'b1; d_addr = 16'h0200;
    txn("sim1_d", 2, 1'b0, 0, 1'b0, 16'h1111, 1'b0);
    txn("sim1_i", 2, 1'b0, 0, 1'b0, 16'h2222, 1'b0);
    i_rd = 1'b1; i_addr = 16'h0104; d_rd = 1'b1; d_addr = 16'h0204;
    txn("sim2_d", 1, 1'b0, 0, 1'b0, 16'h3333, 1'b0);
    txn("sim2_i", 1, 1'b0, 0, 1'b0, 16'h4444, 1'b0);

    // Fetch only, mem_done in the 3rd BUSY cycle.
    i_rd = 1'b1; i_addr = 16'h0010;
    txn("fetch", 3, 1'b0, 0, 1'b0, 16'h1234, 1'b0);

    // Read+write together: write wins, write data held.
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_data_in = 16'hBEEF;
    txn("wprio", 3, 1'b0, 0, 1'b0, 16'h0000, 1'b0);

    // Fetch dropped mid-transaction: completes silently.
    i_rd = 1'b1; i_addr = 16'h0020;
    txn("drop", 4, 1'b0, 2, 1'b0, 16'h5678, 1'b0);

    // Watchdog timeout on a fetch.
    i_rd = 1'b1; i_addr = 16'h0030;
    txn("tmo", 0, 1'b1, 0, 1'b0, 16'h0000, 1'b0);

    // Error passthrough on D, with a stray mem_done while idle.
    d_rd = 1'b1; d_addr = 16'h0050;
    txn("err", 2, 1'b0, 0, 1'b1, 16'hA5A5, 1'b1);

    // Reset in the middle of a D write; prio is I beforehand.
    d_wr = 1'b1; d_addr = 16'h0300; d_data_in = 16'h5555;
    tick();
    chk("rstmid:busy_wr", mem_wr, 32'd1);
    rst = 1'b1; d_wr = 1'b0;
    tick();
    rst = 1'b0;
    m_prio_d = 1'b1;
    #1;
    chk("rstmid:mem_rdwr", {mem_rd, mem_wr}, 32'd0);
    chk("rstmid:mem_addr", mem_addr, 32'd0);
    chk("rstmid:mem_data_in", mem_data_in, 32'd0);
    mem_done = 1'b1; mem_data_out = 16'h7777;
    #1;
    chk("rstmid:late_done", d_done, 32'd0);
    chk("rstmid:late_data", d_data_out, 32'd0);
    tick();
    mem_done = 1'b0;
    i_rd = 1'b1; i_addr = 16'h0400; d_rd = 1'b1; d_addr = 16'h0500;
    txn("rstmid_prio_d", 1, 1'b0, 0, 1'b0, 16'h0101, 1'b0);
    txn("rstmid_then_i", 1, 1'b0, 0, 1'b0, 16'h0202, 1'b0);

    // Random rounds: losers stay pending across rounds.
    for (int r = 0; r < 40; r++) begin
      if (!i_rd && ($urandom_range(0, 1) == 1)) begin
        i_rd = 1'b1; i_addr = 16'($urandom);
      end
      if (!(d_rd | d_wr) && ($urandom_range(0, 1) == 1)) begin
        op = $urandom_range(0, 2);
        d_rd = (op != 1); d_wr = (op != 0);
        d_addr = 16'($urandom); d_data_in = 16'($urandom);
      end
      if (!i_rd && !(d_rd | d_wr)) begin
        i_rd = 1'b1; i_addr = 16'($urandom);
      end
      txn("rnd", $urandom_range(1, 5), 1'b0, ($urandom_range(0, 4) == 0) ? 1 : 0,
          1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
